// File: rtl/mem_access_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_sequencer_if
//  Purpose  : Avalon-MM-style memory bus between the access sequencer
//             (master) and the external memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface mem_access_sequencer_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [3:0]        byteenable;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_sequencer
//  Purpose  : Turns fetch / MemRead / MemWrite requests from the control unit
//             into bus transactions and returns the instruction word, load
//             data and instruction-completion pulses. Halts the CPU on a
//             fetch from PC 0 or on a bus timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_sequencer #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              fetch,
    input  wire logic [31:0]       pc,
    input  wire logic              mem_read,
    input  wire logic              mem_write,
    input  wire logic [31:0]       data_addr,
    input  wire logic [DATA_W-1:0] store_data,
    input  wire logic [3:0]        store_be,
    output logic [DATA_W-1:0]      instr,
    output logic                   instr_valid,
    output logic [DATA_W-1:0]      load_data,
    output logic                   end_of_inst_reg,
    output logic                   end_of_inst_store,
    output logic                   active,
    output logic                   bus_err,
    mem_access_sequencer_if.master bus
);

    // Counter must hold values up to MAX_WAIT-1; keep at least one bit so
    // the MAX_WAIT==0 (unlimited) build still elaborates.
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam bit   WAIT_LIMITED = (MAX_WAIT != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_STORE  = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        address_q, address_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  writedata_q, writedata_d;
    logic [3:0]         be_q, be_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic [DATA_W-1:0]  load_data_q, load_data_d;
    logic               eoi_reg_q, eoi_reg_d;
    logic               eoi_store_q, eoi_store_d;
    logic               active_q, active_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    // A stalled cycle that exhausts the wait budget aborts the transaction.
    logic w_timeout;
    assign w_timeout = WAIT_LIMITED && bus.waitrequest && (wait_cnt_q == WAIT_LAST);

    // State and all registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            address_q     <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            writedata_q   <= '0;
            be_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            load_data_q   <= '0;
            eoi_reg_q     <= 1'b0;
            eoi_store_q   <= 1'b0;
            active_q      <= 1'b1;
            bus_err_q     <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            read_q        <= read_d;
            write_q       <= write_d;
            writedata_q   <= writedata_d;
            be_q          <= be_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            load_data_q   <= load_data_d;
            eoi_reg_q     <= eoi_reg_d;
            eoi_store_q   <= eoi_store_d;
            active_q      <= active_d;
            bus_err_q     <= bus_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Next-state and next-output decode; pulses default low every cycle.
    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        read_d        = read_q;
        write_d       = write_q;
        writedata_d   = writedata_q;
        be_d          = be_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        load_data_d   = load_data_q;
        eoi_reg_d     = 1'b0;
        eoi_store_d   = 1'b0;
        active_d      = active_q;
        bus_err_d     = bus_err_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (fetch) begin
                    if (pc == 32'd0) begin
                        state_d  = ST_HALTED;
                        active_d = 1'b0;
                    end else begin
                        state_d    = ST_FETCH;
                        address_d  = pc;
                        read_d     = 1'b1;
                        be_d       = 4'hF;
                        wait_cnt_d = '0;
                    end
                end
            end

            ST_FETCH, ST_LOAD, ST_STORE: begin
                if (w_timeout) begin
                    state_d   = ST_HALTED;
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    bus_err_d = 1'b1;
                    active_d  = 1'b0;
                end else if (bus.waitrequest) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (state_q == ST_FETCH) begin
                        instr_d       = bus.readdata;
                        instr_valid_d = 1'b1;
                        state_d       = ST_EXEC;
                    end else if (state_q == ST_LOAD) begin
                        load_data_d = bus.readdata;
                        eoi_reg_d   = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        eoi_store_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_EXEC: begin
                // Load takes priority if control asserts both strobes.
                if (mem_read) begin
                    state_d    = ST_LOAD;
                    address_d  = data_addr;
                    read_d     = 1'b1;
                    be_d       = 4'hF;
                    wait_cnt_d = '0;
                end else if (mem_write) begin
                    state_d     = ST_STORE;
                    address_d   = data_addr;
                    write_d     = 1'b1;
                    writedata_d = store_data;
                    be_d        = store_be;
                    wait_cnt_d  = '0;
                end else begin
                    eoi_reg_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_HALTED: begin
                read_d   = 1'b0;
                write_d  = 1'b0;
                active_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    assign bus.address        = address_q;
    assign bus.read           = read_q;
    assign bus.write          = write_q;
    assign bus.writedata      = writedata_q;
    assign bus.byteenable     = be_q;
    assign instr              = instr_q;
    assign instr_valid        = instr_valid_q;
    assign load_data          = load_data_q;
    assign end_of_inst_reg    = eoi_reg_q;
    assign end_of_inst_store  = eoi_store_q;
    assign active             = active_q;
    assign bus_err            = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_sequencer
//  Purpose  : Directed self-checking bench for mem_access_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch;
    logic [31:0] pc;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_addr;
    logic [31:0] store_data;
    logic [3:0]  store_be;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] load_data;
    logic        end_of_inst_reg;
    logic        end_of_inst_store;
    logic        active;
    logic        bus_err;

    int passed = 0;
    int total  = 0;

    mem_access_sequencer_if #(.DATA_W(32)) bus ();

    mem_access_sequencer #(.DATA_W(32), .MAX_WAIT(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .fetch             (fetch),
        .pc                (pc),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .data_addr         (data_addr),
        .store_data        (store_data),
        .store_be          (store_be),
        .instr             (instr),
        .instr_valid       (instr_valid),
        .load_data         (load_data),
        .end_of_inst_reg   (end_of_inst_reg),
        .end_of_inst_store (end_of_inst_store),
        .active            (active),
        .bus_err           (bus_err),
        .bus               (bus.master)
    );

    always #5 clk = ~clk;

    // Advance one active edge; inputs change and outputs are sampled at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Fetch one instruction with no stall; leaves the DUT in EXEC.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word);
        pc = addr; fetch = 1'b1; bus.waitrequest = 1'b0; bus.readdata = word;
        step();
        fetch = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; fetch = 1'b0; pc = '0; mem_read = 1'b0; mem_write = 1'b0;
        data_addr = '0; store_data = '0; store_be = '0;
        bus.readdata = '0; bus.waitrequest = 1'b0;
        @(negedge clk);
        step();
        step();

        // Reset state
        chk("rst_read",    32'(bus.read), 32'd0);
        chk("rst_write",   32'(bus.write), 32'd0);
        chk("rst_addr",    bus.address, 32'd0);
        chk("rst_be",      32'(bus.byteenable), 32'd0);
        chk("rst_instr",   instr, 32'd0);
        chk("rst_active",  32'(active), 32'd1);
        chk("rst_buserr",  32'(bus_err), 32'd0);
        reset = 1'b1;

        // Plain fetch, no memory op
        pc = 32'h100; fetch = 1'b1; bus.waitrequest = 1'b0; bus.readdata = 32'h012A4020;
        step();
        chk("f1_read",     32'(bus.read), 32'd1);
        chk("f1_addr",     bus.address, 32'h100);
        chk("f1_be",       32'(bus.byteenable), 32'hF);
        chk("f1_ivalid0",  32'(instr_valid), 32'd0);
        fetch = 1'b0;
        step();
        chk("f1_read_off", 32'(bus.read), 32'd0);
        chk("f1_instr",    instr, 32'h012A4020);
        chk("f1_ivalid",   32'(instr_valid), 32'd1);
        chk("f1_eoi_early",32'(end_of_inst_reg), 32'd0);
        step();
        chk("f1_ivalid_lo",32'(instr_valid), 32'd0);
        chk("f1_eoi",      32'(end_of_inst_reg), 32'd1);
        step();
        chk("f1_eoi_lo",   32'(end_of_inst_reg), 32'd0);
        chk("f1_idle_rd",  32'(bus.read), 32'd0);

        // Load with three stall cycles
        do_fetch(32'h104, 32'h8C880000);
        mem_read = 1'b1; data_addr = 32'h2000; bus.waitrequest = 1'b1; bus.readdata = '0;
        step();
        mem_read = 1'b0; data_addr = 32'h9999;
        for (int i = 0; i < 4; i++) begin
            chk("ld_read_held", 32'(bus.read), 32'd1);
            chk("ld_addr_held", bus.address, 32'h2000);
            chk("ld_no_eoi",    32'(end_of_inst_reg), 32'd0);
            if (i < 3) step();
        end
        bus.waitrequest = 1'b0; bus.readdata = 32'hDEADBEEF;
        step();
        chk("ld_read_off", 32'(bus.read), 32'd0);
        chk("ld_data",     load_data, 32'hDEADBEEF);
        chk("ld_eoi",      32'(end_of_inst_reg), 32'd1);
        bus.readdata = 32'h0;
        step();
        chk("ld_eoi_lo",   32'(end_of_inst_reg), 32'd0);
        chk("ld_data_hold",load_data, 32'hDEADBEEF);

        // Store with one stall cycle
        do_fetch(32'h108, 32'hAD880004);
        mem_write = 1'b1; data_addr = 32'h3004; store_data = 32'h55AA; store_be = 4'b0011;
        bus.waitrequest = 1'b1;
        step();
        mem_write = 1'b0; store_data = 32'h0; store_be = 4'hF;
        chk("st_write",    32'(bus.write), 32'd1);
        chk("st_read",     32'(bus.read), 32'd0);
        chk("st_addr",     bus.address, 32'h3004);
        chk("st_wdata",    bus.writedata, 32'h55AA);
        chk("st_be",       32'(bus.byteenable), 32'h3);
        step();
        chk("st_write_held", 32'(bus.write), 32'd1);
        chk("st_wdata_held", bus.writedata, 32'h55AA);
        bus.waitrequest = 1'b0;
        step();
        chk("st_write_off",32'(bus.write), 32'd0);
        chk("st_eoi_store",32'(end_of_inst_store), 32'd1);
        chk("st_no_eoi_reg",32'(end_of_inst_reg), 32'd0);
        step();
        chk("st_eois_lo",  32'(end_of_inst_store), 32'd0);

        // Both MemRead and MemWrite: load wins
        do_fetch(32'h10C, 32'h00000000);
        mem_read = 1'b1; mem_write = 1'b1; data_addr = 32'h4000; store_data = 32'h1234;
        bus.waitrequest = 1'b0; bus.readdata = 32'hCAFEF00D;
        step();
        mem_read = 1'b0; mem_write = 1'b0;
        chk("rw_read",     32'(bus.read), 32'd1);
        chk("rw_write",    32'(bus.write), 32'd0);
        chk("rw_be",       32'(bus.byteenable), 32'hF);
        step();
        chk("rw_data",     load_data, 32'hCAFEF00D);
        chk("rw_eoi_reg",  32'(end_of_inst_reg), 32'd1);
        chk("rw_eoi_store",32'(end_of_inst_store), 32'd0);
        step();

        // Reset in the middle of a stalled load
        do_fetch(32'h110, 32'h8C880000);
        mem_read = 1'b1; data_addr = 32'h5000; bus.waitrequest = 1'b1;
        step();
        mem_read = 1'b0;
        chk("rl_read",     32'(bus.read), 32'd1);
        reset = 1'b0;
        step();
        chk("rl_read_off", 32'(bus.read), 32'd0);
        chk("rl_no_eoi",   32'(end_of_inst_reg), 32'd0);
        chk("rl_ldata",    load_data, 32'd0);
        chk("rl_active",   32'(active), 32'd1);
        reset = 1'b1; bus.waitrequest = 1'b0;
        pc = 32'h120; fetch = 1'b1;
        step();
        fetch = 1'b0;
        chk("rl_idle_fetch", 32'(bus.read), 32'd1);
        chk("rl_idle_addr",  bus.address, 32'h120);
        step();
        step();

        // Fetch from PC 0 halts without touching the bus
        pc = 32'h0; fetch = 1'b1;
        step();
        chk("h_active",    32'(active), 32'd0);
        chk("h_read",      32'(bus.read), 32'd0);
        pc = 32'h200;
        step();
        chk("h_ignore_rd", 32'(bus.read), 32'd0);
        chk("h_ignore_act",32'(active), 32'd0);
        fetch = 1'b0;

        // Bus timeout: waitrequest stuck during fetch, MAX_WAIT=4
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("to_rst_active", 32'(active), 32'd1);
        pc = 32'h300; fetch = 1'b1; bus.waitrequest = 1'b1;
        step();
        fetch = 1'b0;
        chk("to_read",     32'(bus.read), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_stall_rd",  32'(bus.read), 32'd1);
            chk("to_stall_err", 32'(bus_err), 32'd0);
        end
        step();
        chk("to_buserr",   32'(bus_err), 32'd1);
        chk("to_active",   32'(active), 32'd0);
        chk("to_read_off", 32'(bus.read), 32'd0);
        bus.waitrequest = 1'b0; fetch = 1'b1;
        step();
        chk("to_sticky",   32'(bus_err), 32'd1);
        chk("to_halt_rd",  32'(bus.read), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
